design1_toggle_monitor: RTL and testbench
=========================================

Name: design1_toggle_monitor

Overview:
- Downstream observation stage for the design1 combinational netlist (14 primary inputs, 8 primary outputs: n6, n9, n42, n48, n56, n65, n68, n77).
- Each sample is one applied input vector plus the netlist's settled response. The block counts per-bit toggles across a fixed window of samples.
- Counts feed switching-activity and power estimation for the mapped netlist. They are read back through an indexed port after the window completes.

Parameters:
- IN_W, 14, width of the netlist input vector.
- OUT_W, 8, width of the netlist output vector.
- CNT_W, 16, width of each per-bit saturating toggle counter.
- WIN_LEN, 256, samples per window (including the reference sample); legal range 2..65535.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; arms a new window (honoured only in IDLE).
- in_vec  in  IN_W  input vector applied to the netlist, packed {n80,n78,n75,n72,n67,n57,n51,n35,n34,n22,n18,n12,n4,n2}.
- out_vec  in  OUT_W  netlist response, packed {n77,n68,n65,n56,n48,n42,n9,n6}.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- busy  out  1  high in ARMED or COUNT.
- done  out  1  one-cycle pulse on window completion.
- rd_sel  in  5  counter index: 0..IN_W-1 selects input bits; IN_W..IN_W+OUT_W-1 selects output bits; anything else reads 0.
- rd_count  out  CNT_W  registered counter readback.
- total_out_toggles  out  CNT_W+5  saturating sum of all output-bit toggles in the window.

Behaviour:
- Reset values: state=IDLE; s_ready=0, busy=0, done=0, rd_count=0, total_out_toggles=0; all counters, the previous-sample register and the sample count cleared. Reset mid-window abandons the window; no done pulse.
- FSM states:
  - IDLE: s_ready=0. start moves to ARMED and clears all counters and the total in the same edge.
  - ARMED: s_ready=1. The first accepted sample is stored as prev={in_vec,out_vec}, no toggles are counted, and the sample count is set to 1. Moves to COUNT.
  - COUNT: s_ready=1. Each accepted sample does the following:
    - diff = {in_vec,out_vec} ^ prev; each counter with its diff bit set increments by 1, saturating at 2^CNT_W-1.
    - total_out_toggles += popcount(diff[OUT_W-1:0]), saturating at all-ones.
    - prev updates; the sample count increments.
    - When the sample count reaches WIN_LEN on that acceptance, move to DONE.
  - DONE: s_ready=0; done=1 for exactly this cycle; next state is IDLE.
- start in ARMED, COUNT or DONE is ignored. start coinciding with rst is lost (reset wins).
- A sample is never accepted in the same cycle that start is seen in IDLE, because s_ready is still 0.
- s_valid with s_ready=0 is not accepted and is not buffered; the upstream source holds it.
- Stalls (s_valid=0) in ARMED or COUNT leave all state unchanged. There is no timeout.
- Counter updates are visible at the edge of acceptance. rd_count = counter[rd_sel] registered, so it has one cycle of latency from rd_sel and from counter updates.
- Counters and total hold their values through DONE and IDLE until the next start. Readback is legal at any time.
- Saturation: a counter at max stays at max and never wraps. The total saturates independently of the counters.

Decomposition:
- Package design1_mon_pkg: IN_W and OUT_W constants; state enum {IDLE, ARMED, COUNT, DONE}; rd_sel base constants SEL_IN_BASE=0 and SEL_OUT_BASE=IN_W; netlist pin-order bit-index constants.
- Sub-module toggle_cnt_sat (CNT_W): clk, rst, clr, inc → count, saturating. Instantiated IN_W+OUT_W times via generate.
- FSM, diff/popcount logic and readback mux stay in the top module.

Test Plan:
- Reset → all outputs 0 and s_ready=0. Assert rst mid-COUNT after 3 samples → state IDLE, counters 0, no done pulse.
- WIN_LEN=4; start, then samples out_vec=00,FF,00,FF with in_vec=0 → done on the 4th acceptance; each output counter=3; total_out_toggles=24; every input counter=0.
- WIN_LEN=4; in_vec samples 0001,0000,0001,0001 (n2 bit only) → counter[0]=2, all others 0, total=0.
- Insert s_valid=0 gaps of 5 cycles between samples → results identical to the gap-free run; s_ready stays 1 during gaps.
- CNT_W=2, WIN_LEN=10, out_vec bit0 toggling every sample → counter[IN_W]=3 (saturated); total_out_toggles=9.
- start pulsed during COUNT → ignored and window completes normally. rd_sel=25 → rd_count=0. After done, counts stay held until the next start, which clears them.

Source files
------------

// File: rtl/design1_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : design1_mon_pkg
// Brief    : Shared constants, FSM state encoding and netlist pin ordering
//            for the design1 toggle monitor.
// Revision : 1.0 - initial release
// ============================================================================
package design1_mon_pkg;

  // Netlist vector widths (14 primary inputs, 8 primary outputs).
  localparam int IN_W  = 14;
  localparam int OUT_W = 8;

  // Readback index bases: input bits first, then output bits.
  localparam int SEL_IN_BASE  = 0;
  localparam int SEL_OUT_BASE = IN_W;

  // Window control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  // Bit position of each netlist primary input inside in_vec.
  typedef enum int {
    PIN_N2  = 0,  PIN_N4  = 1,  PIN_N12 = 2,  PIN_N18 = 3,
    PIN_N22 = 4,  PIN_N34 = 5,  PIN_N35 = 6,  PIN_N51 = 7,
    PIN_N57 = 8,  PIN_N67 = 9,  PIN_N72 = 10, PIN_N75 = 11,
    PIN_N78 = 12, PIN_N80 = 13
  } in_pin_e;

  // Bit position of each netlist primary output inside out_vec.
  typedef enum int {
    PIN_N6  = 0, PIN_N9  = 1, PIN_N42 = 2, PIN_N48 = 3,
    PIN_N56 = 4, PIN_N65 = 5, PIN_N68 = 6, PIN_N77 = 7
  } out_pin_e;

endpackage
`default_nettype wire

// File: rtl/design1_toggle_monitor_cnt.sv
`default_nettype none
// ============================================================================
// Module   : toggle_cnt_sat
// Brief    : Single per-bit toggle counter; synchronous clear, saturating
//            increment (never wraps past all-ones).
// Revision : 1.0 - initial release
// ============================================================================
module toggle_cnt_sat #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority; increment stops once the counter is at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/design1_toggle_monitor.sv
`default_nettype none
// ============================================================================
// Module   : design1_toggle_monitor
// Brief    : Counts per-bit toggles of the design1 netlist inputs/outputs over
//            a window of WIN_LEN samples; indexed registered readback and a
//            saturating total of output-bit toggles.
// Revision : 1.0 - initial release
// ============================================================================
module design1_toggle_monitor
  import design1_mon_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int WIN_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  in_vec,
  input  logic [OUT_W-1:0] out_vec,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  input  logic [4:0]       rd_sel,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W+4:0] total_out_toggles
);

  localparam int NB     = IN_W + OUT_W;
  localparam int TOT_W  = CNT_W + 5;
  localparam int SCNT_W = 16;
  localparam int POP_W  = $clog2(OUT_W + 1);

  mon_state_e       state_q, state_d;
  logic [NB-1:0]    prev_q, prev_d;
  logic [SCNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;

  logic             accept;
  logic             count_accept;
  logic             clr_cnt;
  logic [NB-1:0]    diff;
  logic [NB-1:0]    tog_inc;
  logic [POP_W-1:0] out_pop;
  logic [TOT_W:0]   total_sum;
  logic [CNT_W-1:0] cnt_val [NB];

  // Handshake/status decode and per-sample difference against the previous sample.
  always_comb begin
    s_ready      = (state_q == ARMED) || (state_q == COUNT);
    busy         = s_ready;
    done         = (state_q == DONE);
    accept       = s_valid && s_ready;
    count_accept = accept && (state_q == COUNT);
    clr_cnt      = (state_q == IDLE) && start;
    diff         = {in_vec, out_vec} ^ prev_q;
    // Counter order matches rd_sel: input bits low, output bits high.
    tog_inc      = {diff[OUT_W-1:0], diff[NB-1:OUT_W]} & {NB{count_accept}};
  end

  // Window FSM: next state, reference sample and sample count.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    smp_cnt_d = smp_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
      end
      ARMED: begin
        if (accept) begin
          prev_d    = {in_vec, out_vec};
          smp_cnt_d = SCNT_W'(1);
          state_d   = COUNT;
        end
      end
      COUNT: begin
        if (accept) begin
          prev_d    = {in_vec, out_vec};
          smp_cnt_d = smp_cnt_q + 1'b1;
          if ((smp_cnt_q + 1'b1) == SCNT_W'(WIN_LEN)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output-bit toggle popcount folded into the saturating total.
  always_comb begin
    out_pop = '0;
    for (int i = 0; i < OUT_W; i++) begin
      out_pop = out_pop + POP_W'(diff[i]);
    end
    total_sum = {1'b0, total_q} + (TOT_W + 1)'(out_pop);
    total_d   = total_q;
    if (clr_cnt) begin
      total_d = '0;
    end else if (count_accept) begin
      total_d = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
    end
  end

  // Readback mux; indices beyond the last counter read zero.
  always_comb begin
    rd_count_d = '0;
    for (int k = 0; k < IN_W; k++) begin
      if (int'(rd_sel) == SEL_IN_BASE + k) rd_count_d = cnt_val[k];
    end
    for (int j = 0; j < OUT_W; j++) begin
      if (int'(rd_sel) == SEL_OUT_BASE + j) rd_count_d = cnt_val[IN_W + j];
    end
  end

  // State, reference sample, sample count, total and readback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      smp_cnt_q  <= '0;
      total_q    <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      smp_cnt_q  <= smp_cnt_d;
      total_q    <= total_d;
      rd_count_q <= rd_count_d;
    end
  end

  generate
    for (genvar k = 0; k < NB; k++) begin : g_cnt
      toggle_cnt_sat #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (tog_inc[k]),
        .count (cnt_val[k])
      );
    end
  endgenerate

  assign rd_count          = rd_count_q;
  assign total_out_toggles = total_q;

endmodule
`default_nettype wire

// File: tb/tb_design1_toggle_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_design1_toggle_monitor
// Brief    : Directed self-checking bench for design1_toggle_monitor.
//            dut_a: CNT_W=16, WIN_LEN=4.  dut_b: CNT_W=2, WIN_LEN=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_design1_toggle_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // dut_a stimulus / response
  logic        start_a = 1'b0;
  logic [13:0] in_a    = '0;
  logic [7:0]  out_a   = '0;
  logic        s_valid_a = 1'b0;
  logic [4:0]  rd_sel_a  = '0;
  logic        s_ready_a, busy_a, done_a;
  logic [15:0] rd_count_a;
  logic [20:0] total_a;

  // dut_b stimulus / response
  logic        start_b = 1'b0;
  logic [13:0] in_b    = '0;
  logic [7:0]  out_b   = '0;
  logic        s_valid_b = 1'b0;
  logic [4:0]  rd_sel_b  = '0;
  logic        s_ready_b, busy_b, done_b;
  logic [1:0]  rd_count_b;
  logic [6:0]  total_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  design1_toggle_monitor #(.CNT_W(16), .WIN_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_vec(in_a), .out_vec(out_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .busy(busy_a), .done(done_a),
    .rd_sel(rd_sel_a), .rd_count(rd_count_a), .total_out_toggles(total_a)
  );

  design1_toggle_monitor #(.CNT_W(2), .WIN_LEN(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_vec(in_b), .out_vec(out_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .busy(busy_b), .done(done_b),
    .rd_sel(rd_sel_b), .rd_count(rd_count_b), .total_out_toggles(total_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic send_a(input logic [13:0] iv, input logic [7:0] ov);
    in_a = iv;
    out_a = ov;
    s_valid_a = 1'b1;
    tick();
    s_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [13:0] iv, input logic [7:0] ov);
    in_b = iv;
    out_b = ov;
    s_valid_b = 1'b1;
    tick();
    s_valid_b = 1'b0;
  endtask

  task automatic gap_a(input int n);
    for (int g = 0; g < n; g++) begin
      tick();
      chk("gap_s_ready", 32'(s_ready_a), 32'd1);
    end
  endtask

  task automatic read_a(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    rd_sel_a = idx;
    tick();
    chk(tag, 32'(rd_count_a), exp);
  endtask

  task automatic read_b(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    rd_sel_b = idx;
    tick();
    chk(tag, 32'(rd_count_b), exp);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) tick();
    chk("rst_s_ready", 32'(s_ready_a), 32'd0);
    chk("rst_busy",    32'(busy_a),    32'd0);
    chk("rst_done",    32'(done_a),    32'd0);
    chk("rst_rd",      32'(rd_count_a), 32'd0);
    chk("rst_total",   32'(total_a),   32'd0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", 32'(s_ready_a), 32'd0);

    // ---------------- output toggles 00,FF,00,FF ----------------
    pulse_start_a();
    chk("armed_busy",    32'(busy_a),    32'd1);
    chk("armed_s_ready", 32'(s_ready_a), 32'd1);
    send_a(14'h0, 8'h00);
    chk("w1_done_s1", 32'(done_a), 32'd0);
    send_a(14'h0, 8'hFF);
    send_a(14'h0, 8'h00);
    chk("w1_done_s3", 32'(done_a), 32'd0);
    chk("w1_total_s3", 32'(total_a), 32'd16);
    send_a(14'h0, 8'hFF);
    chk("w1_done", 32'(done_a), 32'd1);
    chk("w1_s_ready_done", 32'(s_ready_a), 32'd0);
    chk("w1_total", 32'(total_a), 32'd24);
    tick();
    chk("w1_done_one_cycle", 32'(done_a), 32'd0);
    for (int j = 0; j < 8; j++) read_a(5'(14 + j), 32'd3, "w1_out_cnt");
    read_a(5'd0,  32'd0, "w1_in0_cnt");
    read_a(5'd13, 32'd0, "w1_in13_cnt");
    read_a(5'd25, 32'd0, "rd_sel_25");
    read_a(5'd22, 32'd0, "rd_sel_22");
    repeat (3) tick();
    chk("held_total", 32'(total_a), 32'd24);
    chk("held_busy",  32'(busy_a),  32'd0);
    read_a(5'd14, 32'd3, "held_cnt14");

    // ---------------- input bit n2 only ----------------
    pulse_start_a();
    chk("start_clears_total", 32'(total_a), 32'd0);
    read_a(5'd14, 32'd0, "start_clears_cnt14");
    send_a(14'h0001, 8'h00);
    send_a(14'h0000, 8'h00);
    send_a(14'h0001, 8'h00);
    send_a(14'h0001, 8'h00);
    chk("w2_done",  32'(done_a),  32'd1);
    chk("w2_total", 32'(total_a), 32'd0);
    read_a(5'd0,  32'd2, "w2_cnt0");
    read_a(5'd1,  32'd0, "w2_cnt1");
    read_a(5'd14, 32'd0, "w2_cnt14");

    // ---------------- gaps, plus start ignored mid-window ----------------
    pulse_start_a();
    send_a(14'h0, 8'h00);
    gap_a(5);
    send_a(14'h0, 8'hFF);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_ignored_busy", 32'(busy_a), 32'd1);
    gap_a(4);
    send_a(14'h0, 8'h00);
    gap_a(5);
    chk("gap_done_early", 32'(done_a), 32'd0);
    send_a(14'h0, 8'hFF);
    chk("w3_done",  32'(done_a),  32'd1);
    chk("w3_total", 32'(total_a), 32'd24);
    for (int j = 0; j < 8; j++) read_a(5'(14 + j), 32'd3, "w3_out_cnt");
    read_a(5'd0, 32'd0, "w3_in0_cnt");

    // ---------------- reset mid-COUNT ----------------
    pulse_start_a();
    send_a(14'h0, 8'h00);
    send_a(14'h0, 8'hFF);
    send_a(14'h0, 8'h00);
    chk("pre_rst_total", 32'(total_a), 32'd16);
    chk("pre_rst_busy",  32'(busy_a),  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",    32'(busy_a),    32'd0);
    chk("mid_rst_s_ready", 32'(s_ready_a), 32'd0);
    chk("mid_rst_total",   32'(total_a),   32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_rst_no_done", 32'(done_a), 32'd0);
    end
    read_a(5'd14, 32'd0, "mid_rst_cnt14");

    // ---------------- saturation: CNT_W=2, WIN_LEN=10 ----------------
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int s = 0; s < 9; s++) send_b(14'h0, 8'(s % 2));
    chk("sat_done_s9",  32'(done_b),  32'd0);
    chk("sat_total_s9", 32'(total_b), 32'd8);
    send_b(14'h0, 8'h01);
    chk("sat_done",  32'(done_b),  32'd1);
    chk("sat_total", 32'(total_b), 32'd9);
    read_b(5'd14, 32'd3, "sat_cnt14");
    read_b(5'd15, 32'd0, "sat_cnt15");
    read_b(5'd0,  32'd0, "sat_cnt0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
